// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator (address register, MEM/WR stage)
// and the memory responder.
interface mem_responder_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        abort;
    logic        busy;

    modport master (
        output req, we, size, addr, wdata,
        input  rdata, ack, abort, busy
    );

    modport slave (
        input  req, we, size, addr, wdata,
        output rdata, ack, abort, busy
    );
endinterface

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with fixed wait states and a little-endian word array.
// Illegal accesses (bad size, misalignment, out of range) complete early with an abort pulse.
module mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_STATES = 2
) (
    input logic            i_clk1,
    input logic            i_rst,
    mem_responder_if.slave io_bus
);
    localparam int unsigned Depth   = 2 ** ADDR_WIDTH;
    localparam logic [3:0]  WaitCnt = 4'(WAIT_STATES);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                r_state;
    state_e                w_state_next;
    logic [3:0]            r_cnt;
    logic                  r_we;
    logic [1:0]            r_size;
    logic [ADDR_WIDTH+1:0] r_addr;
    logic [31:0]           r_wdata;
    logic                  r_illegal;
    logic [31:0]           r_rdata;
    logic [31:0]           r_mem [Depth];

    logic                  w_accept;
    logic                  w_commit;
    logic                  w_illegal_in;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [31:0]           w_word;
    logic [31:0]           w_shift;
    logic [3:0]            w_be;
    logic [31:0]           w_wr_data;
    logic [31:0]           w_rd_data;

    assign w_accept = (r_state == StIdle) && io_bus.req;
    assign w_commit = (r_state == StWait) && (r_cnt == 4'd0);
    assign w_idx    = r_addr[ADDR_WIDTH+1:2];
    assign w_word   = r_mem[w_idx];
    assign w_shift  = w_word >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_illegal_in = 1'b0;
        case (io_bus.size)
            2'b00:   w_illegal_in = 1'b0;
            2'b01:   w_illegal_in = io_bus.addr[0];
            2'b10:   w_illegal_in = |io_bus.addr[1:0];
            default: w_illegal_in = 1'b1;
        endcase
        if ((io_bus.addr >> (ADDR_WIDTH + 2)) != 32'd0) begin
            w_illegal_in = 1'b1;
        end
    end

    // Byte-lane enables and replicated write data; read data right-aligned, zero-extended.
    always_comb begin
        w_be      = 4'b0000;
        w_wr_data = 32'd0;
        w_rd_data = 32'd0;
        case (r_size)
            2'b00: begin
                w_be      = 4'b0001 << r_addr[1:0];
                w_wr_data = {4{r_wdata[7:0]}};
                w_rd_data = {24'd0, w_shift[7:0]};
            end
            2'b01: begin
                w_be      = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wr_data = {2{r_wdata[15:0]}};
                w_rd_data = {16'd0, (r_addr[1] ? w_word[31:16] : w_word[15:0])};
            end
            default: begin
                w_be      = 4'b1111;
                w_wr_data = r_wdata;
                w_rd_data = w_word;
            end
        endcase
    end

    always_ff @(posedge i_clk1) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (io_bus.req) w_state_next = StWait;
            StWait:  if (r_cnt == 4'd0) w_state_next = StResp;
            StResp:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        io_bus.ack   = (r_state == StResp);
        io_bus.abort = (r_state == StResp) && r_illegal;
        io_bus.busy  = (r_state != StIdle);
        io_bus.rdata = r_rdata;
    end

    always_ff @(posedge i_clk1) begin
        if (i_rst) begin
            r_cnt     <= 4'd0;
            r_we      <= 1'b0;
            r_size    <= 2'b00;
            r_addr    <= '0;
            r_wdata   <= 32'd0;
            r_illegal <= 1'b0;
            r_rdata   <= 32'd0;
        end else begin
            if (w_accept) begin
                r_we      <= io_bus.we;
                r_size    <= io_bus.size;
                r_addr    <= io_bus.addr[ADDR_WIDTH+1:0];
                r_wdata   <= io_bus.wdata;
                r_illegal <= w_illegal_in;
                r_cnt     <= w_illegal_in ? 4'd0 : WaitCnt;
            end else if ((r_state == StWait) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit) begin
                if (r_illegal) begin
                    r_rdata <= 32'd0;
                end else if (!r_we) begin
                    r_rdata <= w_rd_data;
                end
            end
        end
    end

    // Array is deliberately not reset; a reset edge suppresses any pending commit.
    always_ff @(posedge i_clk1) begin
        if (!i_rst && w_commit && !r_illegal && r_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with two wait states, one with none.
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic        abort;
    logic        busy;
    logic [31:0] rdata;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    mem_responder_if b0 ();
    mem_responder_if b1 ();

    assign b0.req   = req & ~sel;
    assign b1.req   = req & sel;
    assign b0.we    = we;
    assign b1.we    = we;
    assign b0.size  = size;
    assign b1.size  = size;
    assign b0.addr  = addr;
    assign b1.addr  = addr;
    assign b0.wdata = wdata;
    assign b1.wdata = wdata;
    assign ack      = sel ? b1.ack   : b0.ack;
    assign abort    = sel ? b1.abort : b0.abort;
    assign busy     = sel ? b1.busy  : b0.busy;
    assign rdata    = sel ? b1.rdata : b0.rdata;

    mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(2)) u_dut0 (
        .i_clk1 (clk),
        .i_rst  (rst),
        .io_bus (b0.slave)
    );

    mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_dut1 (
        .i_clk1 (clk),
        .i_rst  (rst),
        .io_bus (b1.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction; req dropped right after the accept edge.
    task automatic txn(input string tag, input logic w, input logic [1:0] s, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_lat, input logic exp_abort,
                       input logic chk_rd, input logic [31:0] exp_rd);
        int lat;
        we    = w;
        size  = s;
        addr  = a;
        wdata = d;
        req   = 1'b1;
        tick();
        req = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (ack) begin
                lat = k;
                break;
            end
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_abort"}, abort, exp_abort);
        check({tag, "_busy"}, busy, 1'b1);
        if (chk_rd) check({tag, "_rdata"}, rdata, exp_rd);
        tick();
        check({tag, "_pulse"}, {ack, busy}, 2'b00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_b [3];
        int          lat;
        logic        seen;
        exp_b = '{32'h11111111, 32'h22222222, 32'h33333333};

        sel = 1'b0; rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; addr = 0; wdata = 0;
        tick();
        tick();
        check("rst_ack", ack, 1'b0);
        check("rst_abort", abort, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_rdata", rdata, 32'd0);
        sel = 1'b1;
        check("rst1_status", {ack, abort, busy}, 3'b000);
        check("rst1_rdata", rdata, 32'd0);
        sel = 1'b0;
        rst = 1'b0;

        txn("wr_word", 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 3, 1'b0, 1'b1, 32'd0);
        txn("rd_word", 1'b0, 2'b10, 32'h10, 32'h0, 3, 1'b0, 1'b1, 32'hDEADBEEF);
        txn("wr_byte", 1'b1, 2'b00, 32'h11, 32'hFFFFFF55, 3, 1'b0, 1'b1, 32'hDEADBEEF);
        txn("rd_word2", 1'b0, 2'b10, 32'h10, 32'h0, 3, 1'b0, 1'b1, 32'hDEAD55EF);
        txn("rd_half", 1'b0, 2'b01, 32'h12, 32'h0, 3, 1'b0, 1'b1, 32'h0000DEAD);
        txn("rd_byte", 1'b0, 2'b00, 32'h13, 32'h0, 3, 1'b0, 1'b1, 32'h000000DE);
        txn("wr_half", 1'b1, 2'b01, 32'h12, 32'hFFFFBEEF, 3, 1'b0, 1'b0, 32'd0);
        txn("rd_word3", 1'b0, 2'b10, 32'h10, 32'h0, 3, 1'b0, 1'b1, 32'hBEEF55EF);

        txn("wr_w0", 1'b1, 2'b10, 32'h00, 32'h0BADF00D, 3, 1'b0, 1'b0, 32'd0);
        txn("rd_half_mis", 1'b0, 2'b01, 32'h11, 32'h0, 1, 1'b1, 1'b1, 32'd0);
        txn("wr_word_mis", 1'b1, 2'b10, 32'h02, 32'hFFFFFFFF, 1, 1'b1, 1'b1, 32'd0);
        txn("rd_w0", 1'b0, 2'b10, 32'h00, 32'h0, 3, 1'b0, 1'b1, 32'h0BADF00D);
        txn("size11", 1'b0, 2'b11, 32'h00, 32'h0, 1, 1'b1, 1'b1, 32'd0);
        txn("wr_oor", 1'b1, 2'b10, 32'h1000, 32'hFFFFFFFF, 1, 1'b1, 1'b1, 32'd0);
        txn("rd_w0b", 1'b0, 2'b10, 32'h00, 32'h0, 3, 1'b0, 1'b1, 32'h0BADF00D);

        // Inputs scrambled and req dropped after accept.
        we = 1'b1; size = 2'b10; addr = 32'h20; wdata = 32'h12345678; req = 1'b1;
        tick();
        tick();
        req = 1'b0; addr = 32'h24; wdata = 32'h0; we = 1'b0; size = 2'b11;
        lat = 0;
        for (int k = 2; k <= 20; k++) begin
            if (ack) begin
                lat = k - 1;
                break;
            end
            tick();
        end
        check("chg_lat", lat, 3);
        check("chg_abort", abort, 1'b0);
        tick();
        txn("rd_chg", 1'b0, 2'b10, 32'h20, 32'h0, 3, 1'b0, 1'b1, 32'h12345678);

        // Reset during WAIT discards the pending write.
        txn("wr_z30", 1'b1, 2'b10, 32'h30, 32'h0, 3, 1'b0, 1'b0, 32'd0);
        we = 1'b1; size = 2'b10; addr = 32'h30; wdata = 32'hAAAAAAAA; req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstw_status", {ack, abort, busy}, 3'b000);
        check("rstw_rdata", rdata, 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            seen = seen | ack;
        end
        check("rstw_noack", seen, 1'b0);
        txn("rd_30", 1'b0, 2'b10, 32'h30, 32'h0, 3, 1'b0, 1'b1, 32'd0);

        // Reset in the ack cycle: ack drops, committed write survives.
        we = 1'b1; size = 2'b10; addr = 32'h34; wdata = 32'h5A5A5A5A; req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        tick();
        tick();
        check("rstr_ack", ack, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstr_ack_low", {ack, busy}, 2'b00);
        txn("rd_34", 1'b0, 2'b10, 32'h34, 32'h0, 3, 1'b0, 1'b1, 32'h5A5A5A5A);

        // Zero wait states, req held through three reads.
        sel = 1'b1;
        txn("b_wr0", 1'b1, 2'b10, 32'h40, exp_b[0], 1, 1'b0, 1'b0, 32'd0);
        txn("b_wr1", 1'b1, 2'b10, 32'h44, exp_b[1], 1, 1'b0, 1'b0, 32'd0);
        txn("b_wr2", 1'b1, 2'b10, 32'h48, exp_b[2], 1, 1'b0, 1'b0, 32'd0);
        we = 1'b0; size = 2'b10; addr = 32'h40; req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("b2b_pre", ack, 1'b0);
            tick();
            check("b2b_ack", {ack, abort}, 2'b10);
            check("b2b_rdata", rdata, exp_b[i]);
            addr = 32'h44 + 32'(4 * i);
            tick();
            check("b2b_gap", ack, 1'b0);
        end
        req = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
